sample_frontend: RTL and testbench

- Upstream stage of the channel sample buffer: conditions the raw per-channel input bits and delivers one parallel sample word per sample tick.
- Synchronizes each channel, divides the clock into a programmable sample rate and runs a one-shot trigger FSM (arm, trigger, post-trigger count, done).
- Outputs `sample_valid` and `sample_data`, which drive the buffer's shift enable and shift data.

---
 rtl/sample_frontend.sv | 164 ++++++++++++++++
 tb/tb_sample_frontend.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sample_frontend.sv
// Channel sample front end: per-channel synchronizer, programmable sample-rate divider
// and a one-shot trigger FSM. Optional per-channel glitch filter under `GLITCH_FILTER_EN.
module sample_frontend #(
  parameter int NUM_CH      = 7,
  parameter int DIV_WIDTH   = 16,
  parameter int SYNC_STAGES = 2,
  parameter int POST_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ena,
  input  logic [NUM_CH-1:0]     ch_in,
  input  logic [DIV_WIDTH-1:0]  div_value,
  input  logic [NUM_CH-1:0]     trig_mask,
  input  logic [NUM_CH-1:0]     trig_value,
  input  logic [POST_WIDTH-1:0] post_count,
  input  logic                  arm,
  output logic                  sample_valid,
  output logic [NUM_CH-1:0]     sample_data,
  output logic                  trig_flag,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DONE} state_e;

  state_e                          state_q, state_d;
  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
  logic [NUM_CH-1:0]               sync;
  logic [NUM_CH-1:0]               samp;
  logic [DIV_WIDTH-1:0]            div_cnt_q, div_cnt_d;
  logic [POST_WIDTH-1:0]           post_q, post_d;
  logic                            run, tick, match, enter_armed;
  logic                            valid_q, valid_d;
  logic                            trig_q, trig_d;
  logic [NUM_CH-1:0]               data_q, data_d;
  logic                            busy_q, busy_d;
  logic                            done_q, done_d;

  // Synchronizer chain runs every clock regardless of ena or FSM state.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ch_in};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef GLITCH_FILTER_EN
  logic [NUM_CH-1:0] hist1_q, hist2_q, filt_q, filt_d, agree;

  // A level is accepted once the current sync value and the two previous ones all agree.
  always_comb begin
    agree  = ~(sync ^ hist1_q) & ~(hist1_q ^ hist2_q);
    filt_d = (agree & sync) | (~agree & filt_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist1_q <= '0;
      hist2_q <= '0;
      filt_q  <= '0;
    end else begin
      hist1_q <= sync;
      hist2_q <= hist1_q;
      filt_q  <= filt_d;
    end
  end

  assign samp = filt_d;
`else
  assign samp = sync;
`endif

  assign run         = ena && ((state_q == S_ARMED) || (state_q == S_POST));
  assign tick        = run && (div_cnt_q >= div_value);
  assign match       = ((samp & trig_mask) == (trig_value & trig_mask));
  assign enter_armed = ena && arm && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (enter_armed) begin
      div_cnt_d = '0;
    end else if (run) begin
      div_cnt_d = tick ? '0 : div_cnt_q + DIV_WIDTH'(1);
    end
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      div_cnt_q <= '0;
      post_q    <= '0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      post_q    <= post_d;
    end
  end

  // Next-state logic; ena low freezes the FSM and post counter
  always_comb begin
    state_d = state_q;
    post_d  = post_q;
    if (ena) begin
      unique case (state_q)
        S_IDLE: begin
          if (arm) state_d = S_ARMED;
        end
        S_ARMED: begin
          if (tick && match) begin
            post_d  = post_count;
            state_d = (post_count == '0) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          if (tick) begin
            post_d = (post_q != '0) ? post_q - POST_WIDTH'(1) : '0;
            if (post_q <= POST_WIDTH'(1)) state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (arm) state_d = S_ARMED;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    valid_d = tick;
    trig_d  = tick && (state_q == S_ARMED) && match;
    data_d  = tick ? samp : data_q;
    busy_d  = (state_d == S_ARMED) || (state_d == S_POST);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      trig_q  <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      trig_q  <= trig_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sample_valid = valid_q;
  assign sample_data  = data_q;
  assign trig_flag    = trig_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_sample_frontend.sv
// Directed testbench for sample_frontend with hand-computed cycle-by-cycle expectations.
module tb_sample_frontend;

  logic        clk = 1'b0;
  logic        reset;
  logic        ena;
  logic [6:0]  ch_in;
  logic [15:0] div_value;
  logic [6:0]  trig_mask;
  logic [6:0]  trig_value;
  logic [7:0]  post_count;
  logic        arm;
  logic        sample_valid;
  logic [6:0]  sample_data;
  logic        trig_flag;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  sample_frontend #(.NUM_CH(7), .DIV_WIDTH(16), .SYNC_STAGES(2), .POST_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .ena(ena), .ch_in(ch_in), .div_value(div_value),
    .trig_mask(trig_mask), .trig_value(trig_value), .post_count(post_count), .arm(arm),
    .sample_valid(sample_valid), .sample_data(sample_data), .trig_flag(trig_flag),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step(1);
    arm = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ena = 1'b1; ch_in = '0; div_value = '0; trig_mask = '0;
    trig_value = '0; post_count = '0; arm = 1'b0;
    step(3);
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", sample_valid); end
    checks++; if (sample_data !== 7'h00) begin errors++; $display("FAIL reset_data got %h want 00", sample_data); end
    checks++; if (trig_flag !== 1'b0) begin errors++; $display("FAIL reset_trig got %b want 0", trig_flag); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    reset = 1'b0;
    step(2);
  endtask

  task automatic test_immediate();
    div_value = 16'd0; trig_mask = 7'h00; post_count = 8'd3;
    do_arm();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL imm_busy_armed got %b want 1", busy); end
    for (int i = 1; i <= 6; i++) begin
      step(1);
      checks++; if (sample_valid !== (i <= 4)) begin errors++; $display("FAIL imm_valid c%0d got %b want %b", i, sample_valid, (i <= 4)); end
      checks++; if (trig_flag !== (i == 1)) begin errors++; $display("FAIL imm_trig c%0d got %b want %b", i, trig_flag, (i == 1)); end
      checks++; if (done !== (i >= 4)) begin errors++; $display("FAIL imm_done c%0d got %b want %b", i, done, (i >= 4)); end
      checks++; if (busy !== (i < 4)) begin errors++; $display("FAIL imm_busy c%0d got %b want %b", i, busy, (i < 4)); end
    end
  endtask

  task automatic test_divider();
    int pos;
    int dpos;
    div_value = 16'd4; trig_mask = 7'h01; trig_value = 7'h00; post_count = 8'd1; ch_in = 7'h01;
    step(3);
    do_arm();
    for (int i = 1; i <= 20; i++) begin
      step(1);
      checks++; if (sample_valid !== (i % 5 == 0)) begin errors++; $display("FAIL div_valid c%0d got %b want %b", i, sample_valid, (i % 5 == 0)); end
      checks++; if (trig_flag !== 1'b0) begin errors++; $display("FAIL div_notrig c%0d got %b want 0", i, trig_flag); end
    end
    ch_in = 7'h00;
    pos = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      if (pos == 0 && trig_flag === 1'b1) pos = i;
    end
    checks++; if (pos != 5) begin errors++; $display("FAIL div_trig_pos got %0d want 5", pos); end
    dpos = 0;
    for (int i = 9; i <= 16; i++) begin
      step(1);
      if (dpos == 0 && done === 1'b1) dpos = i;
    end
    checks++; if (dpos != 10) begin errors++; $display("FAIL div_done_pos got %0d want 10", dpos); end
  endtask

  task automatic test_pattern();
    logic [6:0] exp_data [9];
    exp_data = '{7'h00, 7'h00, 7'h03, 7'h03, 7'h25, 7'h25, 7'h25, 7'h25, 7'h25};
    div_value = 16'd0; trig_mask = 7'h0F; trig_value = 7'h05; post_count = 8'd2; ch_in = 7'h00;
    step(3);
    do_arm();
    ch_in = 7'h03;
    for (int i = 1; i <= 9; i++) begin
      step(1);
      checks++; if (sample_valid !== (i <= 7)) begin errors++; $display("FAIL pat_valid c%0d got %b want %b", i, sample_valid, (i <= 7)); end
      checks++; if (trig_flag !== (i == 5)) begin errors++; $display("FAIL pat_trig c%0d got %b want %b", i, trig_flag, (i == 5)); end
      checks++; if (sample_data !== exp_data[i-1]) begin errors++; $display("FAIL pat_data c%0d got %h want %h", i, sample_data, exp_data[i-1]); end
      checks++; if (done !== (i >= 7)) begin errors++; $display("FAIL pat_done c%0d got %b want %b", i, done, (i >= 7)); end
      if (i == 2) ch_in = 7'h25;
    end
  endtask

  task automatic test_reset_mid();
    int nvalid;
    int nbusy;
    div_value = 16'd0; trig_mask = 7'h00; post_count = 8'd5;
    do_arm();
    step(3);
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL mid_in_post busy %b done %b want 1 0", busy, done); end
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", sample_valid); end
    checks++; if (sample_data !== 7'h00) begin errors++; $display("FAIL mid_data got %h want 00", sample_data); end
    checks++; if (trig_flag !== 1'b0) begin errors++; $display("FAIL mid_trig got %b want 0", trig_flag); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_done got %b want 0", done); end
    nvalid = 0; nbusy = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (sample_valid === 1'b1) nvalid++;
      if (busy === 1'b1 || done === 1'b1) nbusy++;
    end
    checks++; if (nvalid != 0) begin errors++; $display("FAIL mid_idle_valids got %0d want 0", nvalid); end
    checks++; if (nbusy != 0) begin errors++; $display("FAIL mid_idle_state got %0d want 0", nbusy); end
  endtask

  task automatic test_ena_rearm();
    int  nvalid;
    int  npost;
    bit  seen_trig;
    bit  got_done;
    logic exp_v;
    div_value = 16'd2; trig_mask = 7'h01; trig_value = 7'h00; post_count = 8'd2; ch_in = 7'h25;
    do_arm();
    nvalid = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      exp_v = (i == 3) || (i == 16) || (i == 19);
      if (sample_valid === 1'b1) nvalid++;
      checks++; if (sample_valid !== exp_v) begin errors++; $display("FAIL ena_valid c%0d got %b want %b", i, sample_valid, exp_v); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ena_busy c%0d got %b want 1", i, busy); end
      if (i == 4) ena = 1'b0;
      if (i == 14) ena = 1'b1;
    end
    checks++; if (nvalid != 3) begin errors++; $display("FAIL ena_count got %0d want 3", nvalid); end

    ch_in = 7'h24;
    arm = 1'b1;
    seen_trig = 1'b0; got_done = 1'b0; npost = 0;
    for (int i = 0; i < 40 && !got_done; i++) begin
      step(1);
      if (sample_valid === 1'b1 && seen_trig) npost++;
      if (trig_flag === 1'b1) seen_trig = 1'b1;
      if (done === 1'b1) begin
        got_done = 1'b1;
        arm = 1'b0;
      end
    end
    arm = 1'b0;
    checks++; if (!seen_trig) begin errors++; $display("FAIL hold_trig got 0 want 1"); end
    checks++; if (!got_done) begin errors++; $display("FAIL hold_done got 0 want 1"); end
    checks++; if (npost != 2) begin errors++; $display("FAIL hold_post_pulses got %0d want 2", npost); end

    step(3);
    checks++; if (done !== 1'b1 || sample_valid !== 1'b0) begin errors++; $display("FAIL done_hold done %b valid %b want 1 0", done, sample_valid); end
    do_arm();
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL rearm_state busy %b done %b want 1 0", busy, done); end
    for (int i = 1; i <= 3; i++) begin
      step(1);
      checks++; if (trig_flag !== (i == 3)) begin errors++; $display("FAIL rearm_trig c%0d got %b want %b", i, trig_flag, (i == 3)); end
    end
  endtask

`ifdef GLITCH_FILTER_EN
  task automatic test_glitch();
    int seen;
    reset = 1'b1; step(1); reset = 1'b0;
    div_value = 16'd0; trig_mask = 7'h7F; trig_value = 7'h7F; ch_in = 7'h00;
    step(8);
    do_arm();
    ch_in = 7'h02;
    seen = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      if (i == 2) ch_in = 7'h00;
      if (sample_data[1] === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL glitch_short got %0d want 0", seen); end
    ch_in = 7'h02;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      if (i == 3) ch_in = 7'h00;
      checks++; if (sample_data[1] !== (i >= 5 && i <= 7)) begin errors++; $display("FAIL glitch_long c%0d got %b want %b", i, sample_data[1], (i >= 5 && i <= 7)); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_immediate();
    test_divider();
    test_pattern();
    test_reset_mid();
    test_ena_rearm();
`ifdef GLITCH_FILTER_EN
    test_glitch();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
